// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock)
// with start/busy/done handshake, optional signed input, overflow saturation and leading-zero mask.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  signed_mode,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  negative,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_acc;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_ovf;
  logic             r_neg;

  logic             w_is_neg;
  logic [WIDTH-1:0] w_mag;
  logic [BW-1:0]    w_adj;
  logic [DIGITS-1:0] w_dv;
  logic             w_seen;

  assign w_is_neg = signed_mode & value[WIDTH-1];
  assign w_mag    = w_is_neg ? (~value + WIDTH'(1)) : value;

  // Add-3 correction per digit, applied before each shift
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ? (r_acc[4*gi +: 4] + 4'd3)
                                                           : r_acc[4*gi +: 4];
    end
  endgenerate

  // A digit is significant if it or any more-significant digit is nonzero
  always_comb begin
    w_dv   = '0;
    w_seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_seen = w_seen | (|r_acc[4*i +: 4]);
      w_dv[i] = w_seen;
    end
    w_dv[0] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_CONV;
      S_CONV:   if (r_bit_cnt == '0) w_state_next = S_FINISH;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_acc       <= '0;
      r_bit_cnt   <= '0;
      r_ovf       <= 1'b0;
      r_neg       <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      digit_valid <= DIGITS'(1);
      negative    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= w_mag;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_neg     <= w_is_neg;
            r_bit_cnt <= CW'(WIDTH - 1);
          end
        end
        S_CONV: begin
          // A 1 leaving the top digit means the magnitude needs more digits than we have
          r_acc     <= {w_adj[BW-2:0], r_shift[WIDTH-1]};
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_ovf     <= r_ovf | w_adj[BW-1];
          if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - CW'(1);
        end
        S_FINISH: begin
          done     <= 1'b1;
          negative <= r_neg;
          overflow <= r_ovf;
          if (r_ovf) begin
            bcd         <= {DIGITS{4'h9}};
            digit_valid <= '1;
          end else begin
            bcd         <= r_acc;
            digit_valid <= w_dv;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential, parametrised binary-to-BCD converter that replaces the fixed 20-bit / 6-digit combinational digit splitter on the result-display path. It takes a WIDTH-bit binary result and produces DIGITS packed BCD digits using an iterative shift-add-3 (double-dabble) algorithm, one input bit per clock. Additional features: a start/busy/done handshake, an optional two's-complement signed mode with a sign flag, overflow saturation, and a leading-zero mask for the 7-segment blanking logic. It sits between the arithmetic unit's result register and the display multiplexer.

## Interface
- WIDTH, 20, binary input width; legal range 4..32.
- DIGITS, 6, number of BCD output digits; legal range 1..10.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  WIDTH  binary operand; captured on the accepted start edge.
- signed_mode  input  1  1 = treat value as two's complement; captured with value.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- bcd  output  4*DIGITS  packed BCD; digit i occupies bcd[4i+3:4i], with digit 0 as the units digit.
- digit_valid  output  DIGITS  bit i = 1 if digit i is significant (non-leading-zero).
- negative  output  1  result sign (signed mode only).
- overflow  output  1  magnitude ≥ 10^DIGITS.

## Operation
- FSM states: IDLE, CONV, FINISH.
  - IDLE: on start=1, capture the magnitude into the shift register, clear the BCD accumulator and the sticky overflow bit, set bit_cnt=WIDTH-1, then go to CONV. With start=0, stay in IDLE.
  - CONV: each cycle, first add 3 to every accumulator digit that is ≥5, then shift the {accumulator, shift register} pair left by 1. When bit_cnt=0, go to FINISH; otherwise decrement bit_cnt.
  - FINISH: register the outputs, pulse done, go to IDLE.
- Magnitude: if signed_mode=1 and value[WIDTH-1]=1, magnitude = (~value+1) truncated to WIDTH bits. The most negative input maps to 2^(WIDTH-1), which is correct as an unsigned value. In all other cases the magnitude equals value.
- negative is set to signed_mode & value[WIDTH-1], captured at start.
- Overflow: the sticky bit is set whenever a 1 shifts out of the MSB of the DIGITS-digit accumulator. This is exactly the condition magnitude ≥ 10^DIGITS.
- On overflow:
  - bcd is forced to all digits = 9.
  - digit_valid is forced to all ones.
  - overflow = 1.
  - negative still reflects the sign.
- digit_valid: bit 0 is always 1. For i>0, bit i = 1 if any of digits i..DIGITS-1 is nonzero.
- The accumulator, bit counter and shift register are internal state. Outputs change only at the FINISH edge and hold until the next FINISH or rst.
- start while busy=1 is ignored. It is neither queued nor allowed to corrupt the conversion in progress.
- value and signed_mode may change freely after the accepted start edge.

## Timing
- Reset values: state=IDLE, busy=0, done=0, bcd=0, digit_valid=1 (bit 0 only), negative=0, overflow=0.
- start is accepted at edge k (FSM in IDLE, start=1).
  - busy=1 from after edge k through edge k+WIDTH+1.
  - WIDTH CONV shifts occur at edges k+1 .. k+WIDTH.
  - FINISH occurs at edge k+WIDTH+1.
- done=1 for exactly one cycle following edge k+WIDTH+1, which is also the cycle in which busy returns to 0. Default conversion latency is therefore 21 cycles from start to done.
- Back-to-back: start=1 in the done cycle is accepted, giving a throughput of one conversion per WIDTH+2 cycles.
- rst=1 mid-conversion:
  - state returns to IDLE at the next edge.
  - No done pulse is issued.
  - All outputs take their reset values.
  - rst has priority over start.
- rst and start high in the same cycle: reset wins and start is dropped.

## Test plan
- Unsigned, value=20'd123456, signed_mode=0, start for 1 cycle -> 21 cycles later done=1, bcd=24'h123456, digit_valid=6'b111111, negative=0, overflow=0. busy is high for exactly 21 cycles.
- Zero and boundary:
  - value=0 -> bcd=24'h000000, digit_valid=6'b000001.
  - value=999999 -> bcd=24'h999999, overflow=0.
  - value=1000000 -> overflow=1, bcd=24'h999999, digit_valid=6'b111111.
  - value=20'hFFFFF unsigned -> overflow=1.
- Signed:
  - value=20'hFFF85 (-123), signed_mode=1 -> negative=1, bcd=24'h000123, digit_valid=6'b000111.
  - value=20'h80000 -> negative=1, bcd=24'h524288.
  - the same 20'hFFF85 with signed_mode=0 -> overflow=1.
- Handshake:
  - start pulses during busy are ignored, and the result still matches the first operand.
  - start held high on the done cycle starts a second conversion of 42, which completes 22 cycles after the first done with bcd=24'h000042.
- Reset mid-operation: rst asserted 10 cycles into a conversion -> busy=0 and outputs at reset values next cycle, with no done pulse. A subsequent start converts correctly.
- Parameter sweep: WIDTH=8, DIGITS=3 -> value 255 gives bcd=12'h255 after 9 cycles. WIDTH=8, DIGITS=2 -> value 100 gives overflow=1, bcd=8'h99.
